seg7_tick_counter: RTL and testbench
====================================

Name: seg7_tick_counter

Overview:
Counting core that drives the seven-segment output of the top-level TinyTapeout wrapper. A prescaler divides the system clock into a periodic tick. On each tick a BCD digit advances up or down. The digit is decoded into a registered 7-segment pattern plus a decimal point; the wrapper drives these onto uo_out[6:0] and uo_out[7]. Run, direction, load and load value come from ui_in.

Parameters:
DIV_WIDTH, 24, width of the prescaler counter.
COMPARE, 10000000, prescaler period in clk cycles. Range 2..2^DIV_WIDTH. Default gives 1 Hz at 10 MHz.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state
run  input  1  1 = prescaler and digit advance; 0 = hold
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  4  value to load
digit  output  4  current BCD digit, 0..9
segments  output  7  active-high pattern, bit0 = a .. bit6 = g
dp  output  1  decimal point, toggles on digit wrap
tick  output  1  one-cycle pulse at prescaler terminal count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: prescaler 0, digit 0, tick 0, dp 0, segments 7'h3F (pattern for "0").
- All state updates on the rising clk edge, and only when ena=1. When ena=0, all registers hold, tick is forced 0 and load is ignored.
- Prescaler, when ena=1, run=1, load=0:
  - Increments by 1 each cycle.
  - At COMPARE-1 it wraps to 0 and sets tick=1 for exactly that next cycle. The tick period is COMPARE cycles.
- Prescaler when run=0: holds its value; tick=0.
- Digit update on a tick cycle (registered tick is the enable):
  - up_down=1: digit 9 -> 0, otherwise +1.
  - up_down=0: digit 0 -> 9, otherwise -1.
  - The digit changes in the cycle after tick is high. up_down is sampled in the tick-high cycle.
- Wrap flag: dp toggles in the same cycle the digit wraps (9->0 up or 0->9 down). No other change affects dp.
- Load, when ena=1 and load=1:
  - digit <= load_val if load_val <= 9, else 9 (saturate).
  - Prescaler clears to 0; tick is forced 0 next cycle.
  - A pending tick-driven digit update in the same cycle is discarded.
  - dp is unchanged.
  - Load works regardless of run.
- Priority: reset > ena=0 hold > load > tick-driven step > hold.
- Segment decode: segments is registered from the digit register, so it lags digit by exactly 1 cycle. Table (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - An unreachable digit value decodes to 00.
- Reset mid-operation: immediately (asynchronously) returns all outputs to their reset values. Counting resumes from prescaler 0 after rst_n rises.
- No combinational path from any input to any output.

Test Plan:
- COMPARE=4. Reset, then ena=1, run=1, up_down=1 → tick pulses every 4th cycle; digit 0,1,2,…,9,0. dp goes 0→1 on the 9→0 wrap. segments follows digit one cycle late (e.g. digit=7 then segments=07).
- Direction: up_down=0 from digit 0 → digit 9, 8, 7 on successive ticks; dp toggles at 0→9; segments=6F one cycle after digit=9.
- Load: load=1, load_val=5 mid-period → digit=5 next cycle, prescaler restarts, next tick after exactly 4 cycles. load_val=12 → digit=9 (saturated).
- Load coincident with tick (load asserted in the tick-high cycle) → digit=load_val, no step applied, dp unchanged.
- Hold: run=0 for 10 cycles → no tick, digit and prescaler frozen. ena=0 with load=1 → no change. Re-enable resumes from the same prescaler count.
- Asynchronous reset asserted between clock edges while digit=6, dp=1 → immediately digit=0, dp=0, tick=0, segments=3F.

Source files
------------

// File: rtl/seg7_tick_counter.sv
// Prescaled BCD up/down counter with a registered seven-segment decode.
// The decimal point toggles on each digit wrap.
module seg7_tick_counter #(
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned COMPARE   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       run,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic [6:0] segments,
    output logic       dp,
    output logic       tick
);

    localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(COMPARE - 1);

    logic [DIV_WIDTH-1:0] prescaler;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = '0;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            tick      <= 1'b0;
            digit     <= '0;
            dp        <= 1'b0;
            segments  <= 7'h3F;
        end else if (!ena) begin
            tick <= 1'b0;
        end else begin
            segments <= seg_decode(digit);
            if (load) begin
                // Load wins over a pending step; dp is left alone.
                digit     <= (load_val > 4'd9) ? 4'd9 : load_val;
                prescaler <= '0;
                tick      <= 1'b0;
            end else begin
                if (run) begin
                    if (prescaler == TERM) begin
                        prescaler <= '0;
                        tick      <= 1'b1;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                        tick      <= 1'b0;
                    end
                end else begin
                    tick <= 1'b0;
                end

                if (tick) begin
                    if (up_down) begin
                        if (digit >= 4'd9) begin
                            digit <= '0;
                            dp    <= ~dp;
                        end else begin
                            digit <= digit + 4'd1;
                        end
                    end else begin
                        if (digit == 4'd0) begin
                            digit <= 4'd9;
                            dp    <= ~dp;
                        end else begin
                            digit <= digit - 4'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_tick_counter.sv
// Directed bench for seg7_tick_counter with a per-cycle scoreboard of expected outputs.
module tb_seg7_tick_counter;

    localparam int CMP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, run, up_down, load;
    logic [3:0] load_val;
    logic [3:0] digit;
    logic [6:0] segments;
    logic       dp, tick;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] digit;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t q[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         m_pre, m_digit;
    logic       m_tick, m_dp;
    logic [6:0] m_seg;

    seg7_tick_counter #(.DIV_WIDTH(24), .COMPARE(CMP)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .up_down(up_down),
        .load(load), .load_val(load_val), .digit(digit), .segments(segments),
        .dp(dp), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_digit = 0; m_tick = 1'b0; m_dp = 1'b0; m_seg = 7'h3F;
    endtask

    // Drives one cycle of stimulus, predicts the post-edge outputs, then checks them.
    task automatic cyc(input logic e, input logic r, input logic u, input logic l,
                       input logic [3:0] v);
        int   n_pre, n_digit;
        logic n_tick, n_dp;
        logic [6:0] n_seg;
        exp_t x, y;
        ena = e; run = r; up_down = u; load = l; load_val = v;
        n_pre = m_pre; n_digit = m_digit; n_tick = 1'b0; n_dp = m_dp; n_seg = m_seg;
        if (e) begin
            n_seg = seg_tab[m_digit];
            if (l) begin
                n_digit = (v > 9) ? 9 : int'(v);
                n_pre   = 0;
            end else begin
                if (r) begin
                    if (m_pre == CMP - 1) begin n_pre = 0; n_tick = 1'b1; end
                    else n_pre = m_pre + 1;
                end
                if (m_tick) begin
                    if (u) begin
                        n_digit = (m_digit + 1) % 10;
                        if (m_digit == 9) n_dp = ~m_dp;
                    end else begin
                        n_digit = (m_digit + 9) % 10;
                        if (m_digit == 0) n_dp = ~m_dp;
                    end
                end
            end
        end
        m_pre = n_pre; m_digit = n_digit; m_tick = n_tick; m_dp = n_dp; m_seg = n_seg;
        x.digit = 4'(n_digit); x.seg = n_seg; x.dp = n_dp; x.tick = n_tick;
        q.push_back(x);
        @(posedge clk);
        #1;
        y = q.pop_front();
        check("digit", {4'h0, digit}, {4'h0, y.digit});
        check("segments", {1'b0, segments}, {1'b0, y.seg});
        check("dp", {7'h0, dp}, {7'h0, y.dp});
        check("tick", {7'h0, tick}, {7'h0, y.tick});
        @(negedge clk);
    endtask

    initial begin
        int n, tick_count;
        rst_n = 1'b0; ena = 1'b0; run = 1'b0; up_down = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        check("rst_digit", {4'h0, digit}, 8'h00);
        check("rst_segments", {1'b0, segments}, 8'h3F);
        check("rst_dp", {7'h0, dp}, 8'h00);
        check("rst_tick", {7'h0, tick}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Count up through a full wrap.
        for (int i = 0; i < 44; i++) cyc(1, 1, 1, 0, 4'd0);
        check("up_wrap_digit", {4'h0, digit}, 8'h00);
        check("up_wrap_dp", {7'h0, dp}, 8'h01);

        // Count down: 0 -> 9 -> 8 -> 7.
        for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 4'd0);
        check("down_digit", {4'h0, digit}, 8'h07);
        check("down_dp", {7'h0, dp}, 8'h00);

        // Mid-period load, then the next tick must come exactly CMP cycles later.
        cyc(1, 1, 1, 0, 4'd0);
        cyc(1, 1, 1, 1, 4'd5);
        check("load5_digit", {4'h0, digit}, 8'h05);
        tick_count = 0;
        for (int i = 0; i < CMP; i++) begin
            cyc(1, 1, 1, 0, 4'd0);
            if (tick) tick_count++;
        end
        check("load_tick_after_cmp", {7'h0, tick}, 8'h01);
        check("load_tick_count", 8'(tick_count), 8'h01);
        cyc(1, 1, 1, 1, 4'd12);
        check("load12_sat", {4'h0, digit}, 8'h09);

        // Load in the same cycle tick is high.
        n = 0;
        while (!m_tick && n < 20) begin cyc(1, 1, 0, 0, 4'd0); n++; end
        check("tick_found", {7'h0, m_tick}, 8'h01);
        cyc(1, 1, 0, 1, 4'd3);
        check("load_on_tick", {4'h0, digit}, 8'h03);
        cyc(1, 1, 0, 0, 4'd0);
        check("load_on_tick_nostep", {4'h0, digit}, 8'h03);

        // run=0 hold, then ena=0 with load, then resume.
        cyc(1, 1, 1, 0, 4'd0);
        tick_count = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, 0, 4'd0);
            if (tick) tick_count++;
        end
        check("hold_no_tick", 8'(tick_count), 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 4'd8);
        check("ena0_no_load", {4'h0, digit}, 8'h03);
        for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 4'd0);

        // Run up until digit 6 with dp set, then reset between edges.
        n = 0;
        while (!(m_digit == 6 && m_dp) && n < 200) begin cyc(1, 1, 1, 0, 4'd0); n++; end
        check("reach_6_dp1", {3'h0, m_dp, 4'(m_digit)}, 8'h16);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_digit", {4'h0, digit}, 8'h00);
        check("arst_dp", {7'h0, dp}, 8'h00);
        check("arst_tick", {7'h0, tick}, 8'h00);
        check("arst_segments", {1'b0, segments}, 8'h3F);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 4'd0);

        check("queue_drained", 8'(q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
